// File: rtl/alarm_mode_ctrl_pkg.sv
// alarm_mode_pkg: shared state encoding and helpers for alarm_mode_ctrl.
package alarm_mode_pkg;

  typedef enum logic [2:0] {
    E_TH   = 3'd0,
    E_TM   = 3'd1,
    E_AH   = 3'd2,
    E_AM   = 3'd3,
    RUN    = 3'd4,
    RING   = 3'd5,
    SNOOZE = 3'd6
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic       found;
    logic [2:0] r;
    found = 1'b0;
    r     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        found = 1'b1;
        r     = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_sec_counter.sv
// sec_counter: saturating seconds counter. done pulses combinationally in the
// cycle whose tick brings the count to MAX, so the consumer moves on that edge.
module sec_counter #(
  parameter int MAX = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [W-1:0] cnt_q;

  // Count ticks up to MAX and hold there; clear wins over tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Reaching MAX this cycle, or already parked at MAX.
  always_comb begin
    done = 1'b0;
    if (!clear) begin
      done = (cnt_q == W'(MAX)) || (tick && (cnt_q == W'(MAX - 1)));
    end
  end

endmodule

// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: clock/alarm mode controller with N_ALARMS alarms, an edit
// ring, ringing with snooze and automatic ring timeout.
// Optional: define EDIT_TIMEOUT_EN to leave edit states after EDIT_IDLE_SECS
// seconds without a button pulse.
module alarm_mode_ctrl
  import alarm_mode_pkg::*;
#(
  parameter int N_ALARMS       = 2,
  parameter int RING_SECS      = 60,
  parameter int SNOOZE_SECS    = 300,
  parameter int EDIT_IDLE_SECS = 30,
  localparam int IW            = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                center,
  input  logic                sec_tick,
  input  logic [5:0]          secs,
  input  logic [N_ALARMS-1:0] match,
  output logic                adjust,
  output logic                en_th,
  output logic                en_tm,
  output logic [N_ALARMS-1:0] en_ah,
  output logic [N_ALARMS-1:0] en_am,
  output logic                show_alarm,
  output logic [IW-1:0]       alarm_sel,
  output logic                ringing,
  output logic                snoozing
);

  localparam logic [IW-1:0] LAST = IW'(N_ALARMS - 1);

  if (N_ALARMS < 1 || N_ALARMS > 8 || RING_SECS < 1 || SNOOZE_SECS < 1 ||
      EDIT_IDLE_SECS < 1) begin : g_bad_param
    $error("alarm_mode_ctrl: parameter out of range");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          armed_q, armed_d;
  logic [7:0]    match8;
  logic          is_edit, any_btn, dir_btn, trigger;
  logic          ring_done, snooze_done, idle_done;

  assign dir_btn = up | down | left | right;
  assign any_btn = dir_btn | center;
  assign is_edit = (state_q == E_TH) || (state_q == E_TM) ||
                   (state_q == E_AH) || (state_q == E_AM);
  assign trigger = armed_q && (secs == 6'd0) && (|match);

  // Widen match to the fixed width taken by lowest_set.
  always_comb begin
    match8                 = '0;
    match8[N_ALARMS-1:0]   = match;
  end

  // Counters are held clear outside their state, so entry always starts at 0.
  sec_counter #(.MAX(RING_SECS)) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != RING),
    .tick  (sec_tick),
    .done  (ring_done)
  );

  sec_counter #(.MAX(SNOOZE_SECS)) u_snooze (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != SNOOZE),
    .tick  (sec_tick),
    .done  (snooze_done)
  );

`ifdef EDIT_TIMEOUT_EN
  sec_counter #(.MAX(EDIT_IDLE_SECS)) u_idle (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!is_edit || any_btn),
    .tick  (sec_tick),
    .done  (idle_done)
  );
`else
  assign idle_done = 1'b0;
`endif

  // State, alarm index and re-arm flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= E_TH;
      idx_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    if (secs != 6'd0) armed_d = 1'b1;

    case (state_q)
      E_TH: begin
        if (right) begin
          state_d = E_TM;
          idx_d   = '0;
        end else if (left) begin
          state_d = E_AM;
          idx_d   = LAST;
        end else if (center) begin
          state_d = RUN;
        end
      end
      E_TM: begin
        if (right) begin
          state_d = E_AH;
          idx_d   = '0;
        end else if (left) begin
          state_d = E_TH;
          idx_d   = '0;
        end else if (center) begin
          state_d = RUN;
        end
      end
      E_AH: begin
        if (right) begin
          state_d = E_AM;
        end else if (left) begin
          if (idx_q == '0) begin
            state_d = E_TM;
          end else begin
            state_d = E_AM;
            idx_d   = idx_q - IW'(1);
          end
        end else if (center) begin
          state_d = RUN;
        end
      end
      E_AM: begin
        if (right) begin
          if (idx_q == LAST) begin
            state_d = E_TH;
            idx_d   = '0;
          end else begin
            state_d = E_AH;
            idx_d   = idx_q + IW'(1);
          end
        end else if (left) begin
          state_d = E_AH;
        end else if (center) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (trigger) begin
          state_d = RING;
          idx_d   = IW'(lowest_set(match8));
          armed_d = 1'b0;
        end else if (center) begin
          state_d = E_TH;
          idx_d   = '0;
        end
      end
      RING: begin
        if (dir_btn || ring_done) begin
          state_d = RUN;
        end else if (center) begin
          state_d = SNOOZE;
        end
      end
      SNOOZE: begin
        if (center) begin
          state_d = RUN;
        end else if (snooze_done) begin
          state_d = RING;
        end
      end
      default: state_d = RUN;
    endcase

    // idle_done is only ever high in an edit state with no button pressed.
    if (idle_done) state_d = RUN;
  end

  // Output decode from registered state and index.
  always_comb begin
    adjust     = 1'b0;
    en_th      = 1'b0;
    en_tm      = 1'b0;
    en_ah      = '0;
    en_am      = '0;
    show_alarm = 1'b0;
    ringing    = 1'b0;
    snoozing   = 1'b0;
    alarm_sel  = idx_q;
    case (state_q)
      E_TH: begin
        adjust = 1'b1;
        en_th  = 1'b1;
      end
      E_TM: begin
        adjust = 1'b1;
        en_tm  = 1'b1;
      end
      E_AH: begin
        adjust     = 1'b1;
        show_alarm = 1'b1;
        en_ah      = N_ALARMS'(1) << idx_q;
      end
      E_AM: begin
        adjust     = 1'b1;
        show_alarm = 1'b1;
        en_am      = N_ALARMS'(1) << idx_q;
      end
      RING: begin
        ringing    = 1'b1;
        show_alarm = 1'b1;
      end
      SNOOZE: snoozing = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// tb_alarm_mode_ctrl: directed table plus sequences for alarm_mode_ctrl
// (N_ALARMS=2 defaults). Define EDIT_TIMEOUT_EN to exercise the idle exit.
module tb_alarm_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, down, left, right, center, sec_tick;
  logic [5:0] secs;
  logic [1:0] match;
  logic       adjust, en_th, en_tm, show_alarm, ringing, snoozing;
  logic [1:0] en_ah, en_am;
  logic [0:0] alarm_sel;

  int n_cmp = 0;
  int n_err = 0;

  alarm_mode_ctrl #(
    .N_ALARMS       (2),
    .RING_SECS      (60),
    .SNOOZE_SECS    (300),
    .EDIT_IDLE_SECS (30)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .center     (center),
    .sec_tick   (sec_tick),
    .secs       (secs),
    .match      (match),
    .adjust     (adjust),
    .en_th      (en_th),
    .en_tm      (en_tm),
    .en_ah      (en_ah),
    .en_am      (en_am),
    .show_alarm (show_alarm),
    .alarm_sel  (alarm_sel),
    .ringing    (ringing),
    .snoozing   (snoozing)
  );

  always #5 clk = ~clk;

  // Observed bundle: adjust,en_th,en_tm,en_ah[1:0],en_am[1:0],show,sel,ring,snz
  logic [10:0] obs;
  assign obs = {adjust, en_th, en_tm, en_ah, en_am, show_alarm, alarm_sel,
                ringing, snoozing};

  localparam logic [10:0] O_TH   = 11'b1_1_0_00_00_0_0_0_0;
  localparam logic [10:0] O_TM   = 11'b1_0_1_00_00_0_0_0_0;
  localparam logic [10:0] O_AH0  = 11'b1_0_0_01_00_1_0_0_0;
  localparam logic [10:0] O_AM0  = 11'b1_0_0_00_01_1_0_0_0;
  localparam logic [10:0] O_AH1  = 11'b1_0_0_10_00_1_1_0_0;
  localparam logic [10:0] O_AM1  = 11'b1_0_0_00_10_1_1_0_0;
  localparam logic [10:0] O_RUN0 = 11'b0_0_0_00_00_0_0_0_0;
  localparam logic [10:0] O_RUN1 = 11'b0_0_0_00_00_0_1_0_0;
  localparam logic [10:0] O_RNG0 = 11'b0_0_0_00_00_1_0_1_0;
  localparam logic [10:0] O_RNG1 = 11'b0_0_0_00_00_1_1_1_0;
  localparam logic [10:0] O_SNZ0 = 11'b0_0_0_00_00_0_0_0_1;
  localparam logic [10:0] O_SNZ1 = 11'b0_0_0_00_00_0_1_0_1;

  typedef struct {
    logic        r, l, c, u;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [10:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, l, c, u, d);
    right = r; left = l; center = c; up = u; down = d;
    step();
    right = 0; left = 0; center = 0; up = 0; down = 0;
  endtask

  task automatic ticks(input int n);
    sec_tick = 1'b1;
    repeat (n) step();
    sec_tick = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, O_TM,   "r1_tm"};
    tbl[1]  = '{1, 0, 0, 0, O_AH0,  "r2_ah0"};
    tbl[2]  = '{1, 0, 0, 0, O_AM0,  "r3_am0"};
    tbl[3]  = '{1, 0, 0, 0, O_AH1,  "r4_ah1"};
    tbl[4]  = '{1, 0, 0, 0, O_AM1,  "r5_am1"};
    tbl[5]  = '{1, 0, 0, 0, O_TH,   "r6_th"};
    tbl[6]  = '{0, 1, 0, 0, O_AM1,  "l1_am1"};
    tbl[7]  = '{0, 1, 0, 0, O_AH1,  "l2_ah1"};
    tbl[8]  = '{0, 1, 0, 0, O_AM0,  "l3_am0"};
    tbl[9]  = '{0, 0, 0, 1, O_AM0,  "up_ignored"};
    tbl[10] = '{0, 1, 0, 0, O_AH0,  "l4_ah0"};
    tbl[11] = '{0, 1, 0, 0, O_TM,   "l5_tm"};
    tbl[12] = '{1, 1, 0, 0, O_AH0,  "rl_right_wins"};
    tbl[13] = '{0, 1, 1, 0, O_TM,   "lc_left_wins"};
    tbl[14] = '{0, 0, 1, 0, O_RUN0, "c_to_run"};
    tbl[15] = '{0, 0, 1, 0, O_TH,   "run_c_to_th"};
    tbl[16] = '{0, 0, 1, 0, O_RUN0, "c_to_run2"};

    rst_n = 0; up = 0; down = 0; left = 0; right = 0; center = 0;
    sec_tick = 0; secs = 6'd5; match = '0;
    repeat (2) step();
    check("reset_state", O_TH);
    rst_n = 1;
    step();
    check("after_reset", O_TH);

    // Edit ring walk and RUN entry/exit.
    for (int i = 0; i < 17; i++) begin
      pulse(tbl[i].r, tbl[i].l, tbl[i].c, tbl[i].u, 1'b0);
      check(tbl[i].name, tbl[i].exp);
    end

    // Trigger picks lowest matching alarm; dismiss; no retrigger at secs==0.
    secs = 6'd0; match = 2'b11;
    step();
    check("trig_ring_sel0", O_RNG0);
    pulse(0, 0, 0, 0, 1);
    check("down_dismiss", O_RUN0);
    repeat (3) step();
    check("no_retrigger", O_RUN0);
    secs = 6'd1;
    step();
    check("secs_nonzero_run", O_RUN0);
    secs = 6'd0;
    step();
    check("rearmed_trigger", O_RNG0);

    // Snooze then re-ring at tick 300; ring timeout at tick 60.
    match = '0; secs = 6'd5;
    pulse(0, 0, 1, 0, 0);
    check("center_snooze", O_SNZ0);
    ticks(299);
    check("snooze_299", O_SNZ0);
    ticks(1);
    check("snooze_300_ring", O_RNG0);
    ticks(59);
    check("ring_59", O_RNG0);
    ticks(1);
    check("ring_60_timeout", O_RUN0);

    // Second alarm; cancel snooze early; no ring afterwards.
    secs = 6'd0; match = 2'b10;
    step();
    check("trig_ring_sel1", O_RNG1);
    match = '0; secs = 6'd5;
    pulse(0, 0, 1, 0, 0);
    check("snooze_sel1", O_SNZ1);
    ticks(100);
    pulse(0, 0, 1, 0, 0);
    check("snooze_cancel", O_RUN1);
    ticks(250);
    check("no_ring_after_cancel", O_RUN1);

    // Trigger beats center; center plus another button dismisses.
    secs = 6'd0; match = 2'b01; center = 1;
    step();
    center = 0; match = '0; secs = 6'd5;
    check("trig_beats_center", O_RNG0);
    pulse(0, 0, 1, 1, 0);
    check("center_up_dismiss", O_RUN0);

    // Asynchronous reset in the middle of a snooze.
    secs = 6'd0; match = 2'b01;
    step();
    check("ring_before_rst", O_RNG0);
    match = '0; secs = 6'd5;
    pulse(0, 0, 1, 0, 0);
    ticks(10);
    check("snooze_before_rst", O_SNZ0);
    #2 rst_n = 0;
    #1 check("async_reset", O_TH);
    #2 rst_n = 1;
    step();
    check("after_reset2", O_TH);

`ifdef EDIT_TIMEOUT_EN
    ticks(29);
    check("idle_29", O_TH);
    pulse(0, 0, 0, 1, 0);
    check("idle_up_stays", O_TH);
    ticks(29);
    check("idle_29_after_up", O_TH);
    ticks(1);
    check("idle_30_exit", O_RUN0);
`else
    ticks(40);
    check("no_idle_exit", O_TH);
    pulse(0, 0, 1, 0, 0);
    check("center_exit", O_RUN0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
Name: alarm_mode_ctrl

Overview:
Parametrised successor of the clock/alarm mode controller. It supports N_ALARMS independent alarms, with an edit ring that walks time hours/minutes and then each alarm's hours/minutes. Ringing has snooze and an automatic ring timeout. The block sits between the debounced button pulses and the time/alarm counter banks, and it drives their adjust enables, display select and buzzer enable.

Parameters:
N_ALARMS, 2, number of alarm registers (1..8)
RING_SECS, 60, seconds of ringing before automatic dismiss
SNOOZE_SECS, 300, seconds of snooze before re-ring
EDIT_IDLE_SECS, 30, idle seconds before edit auto-exit (used only with EDIT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up, down, left, right, center  in  1 each  debounced single-cycle button pulses
sec_tick  in  1  one-cycle pulse per elapsed second
secs  in  6  current seconds of time-of-day (0..59)
match  in  N_ALARMS  per-alarm hour:minute equals time-of-day
adjust  out  1  high in any edit state
en_th, en_tm  out  1 each  time hour / minute adjust enable
en_ah, en_am  out  N_ALARMS each  one-hot alarm hour / minute adjust enable
show_alarm  out  1  display shows alarm register alarm_sel
alarm_sel  out  clog2(N_ALARMS) (min 1)  alarm being edited or ringing
ringing  out  1  buzzer enable
snoozing  out  1  snooze in progress

Behaviour:
- States: E_TH, E_TM, E_AH, E_AM, RUN, RING, SNOOZE. A select register idx is used with E_AH/E_AM.
- Reset (async, rst_n=0): state=E_TH, idx=0, all counters=0, armed=1. Outputs: adjust=1, en_th=1, all other outputs 0.
- Edit ring, right-pulse order: E_TH -> E_TM -> E_AH(0) -> E_AM(0) -> E_AH(1) -> ... -> E_AM(N-1) -> E_TH. A left pulse walks the exact reverse.
- Edit priority: right > left > center. Center in any edit state -> RUN.
- Edit outputs: en_th in E_TH; en_tm in E_TM; en_ah[idx] in E_AH; en_am[idx] in E_AM. show_alarm=1 in E_AH/E_AM. up/down are ignored by this block.
- RUN: adjust=0. armed clears when a trigger fires and sets again in any cycle where secs != 0.
- Trigger: armed & secs==0 & |match. On trigger, go to RING with idx = lowest set bit of match. Trigger beats a center pulse in the same cycle.
- RUN, otherwise: center -> E_TH with idx=0.
- RING: ringing=1, show_alarm=1, alarm_sel=idx, ring counter cleared on entry.
  - center -> SNOOZE.
  - Any of up/down/left/right -> RUN (dismiss). A center pulse together with any other button counts as dismiss.
  - ring counter increments on sec_tick. Reaching RING_SECS -> RUN (dismiss).
- SNOOZE: snoozing=1, snooze counter cleared on entry, counts sec_tick.
  - Reaching SNOOZE_SECS -> RING with the same idx.
  - center -> RUN (cancel).
  - Other buttons and new matches are ignored.
- Counter widths: clog2(max value + 1). Counters saturate and never wrap.
- All outputs are decoded combinationally from registered state/idx, so there are no glitches across state codes.
- Illegal state encoding -> RUN on the next clock.
- Transitions take effect on the clk edge after the qualifying input; outputs change that same edge.

Optional Feature:
EDIT_TIMEOUT_EN
- Defined: in edit states, an idle counter counts sec_tick and clears on any button pulse. Reaching EDIT_IDLE_SECS -> RUN. Reset still enters E_TH.
- Undefined: edit states persist until center; there is no idle counter logic.

Decomposition:
- Package alarm_mode_pkg: state enum (E_TH, E_TM, E_AH, E_AM, RUN, RING, SNOOZE) and a function returning the lowest set bit index of a vector.
- Sub-module sec_counter: parametrised MAX, clear, tick inputs, done output, saturating. It is instantiated for ring, snooze and optional idle counting.

Test Plan:
- Reset with N_ALARMS=2, then pulse right 5 times: state sequence E_TM, E_AH(0), E_AM(0), E_AH(1), E_AM(1); en_am=2'b10 at the end. A sixth right -> E_TH. One left from E_TH -> E_AM(1).
- In RUN, set match=2'b11 with secs=0: RING with alarm_sel=0 next cycle. Pulse down -> RUN. Hold secs=0 and match: no retrigger until secs becomes nonzero and returns to 0.
- RING, then center -> SNOOZE. Apply 300 sec_ticks: ringing reasserts on the tick-300 edge with the same alarm_sel. Center in SNOOZE before that -> RUN with no ring.
- RING with no buttons: 60 sec_ticks -> RUN with ringing=0. Also check a ring of 59 ticks is still ringing.
- Trigger and center in the same RUN cycle -> RING. right+left together in E_TM -> E_AH(0). Assert rst_n mid-SNOOZE -> E_TH immediately with snoozing=0.
- With EDIT_TIMEOUT_EN and EDIT_IDLE_SECS=30: 29 ticks, then an up pulse, then 30 ticks -> RUN exactly at tick 30 after the pulse.
